// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array weight/feature sequencer.
package sa_pkg;

    // Default array geometry and vector-count width
    localparam int SA_ROWS  = 4;
    localparam int SA_COLS  = 4;
    localparam int SA_VEC_W = 8;

    // A result leaves column 0 this many cycles after its feature enters row 0
    localparam int OUT_LAT_BASE = SA_ROWS + 1;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } sa_state_e;

    // Address width for n entries, never narrower than one bit
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sa_valid_delay_line.sv
// One-bit shift register exposing every tap; tap k is din delayed k+1 cycles.
module sa_valid_delay_line #(
    parameter int DEPTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [DEPTH-1:0] taps
);

    logic [DEPTH-1:0] taps_q;

    // Shift a new valid bit in every cycle; bubbles enter as 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps_q <= '0;
        end else begin
            taps_q <= {taps_q[DEPTH-2:0], din};
        end
    end

    assign taps = taps_q;

endmodule

// File: rtl/sa_weight_stream_ctrl.sv
// Control sequencer for the weight-stationary MAC array: weight load,
// skewed feature streaming, result-valid generation and job completion.
module sa_weight_stream_ctrl
    import sa_pkg::*;
#(
    parameter  int ROWS  = SA_ROWS,
    parameter  int COLS  = SA_COLS,
    parameter  int VEC_W = SA_VEC_W,
    localparam int AW    = addr_w(ROWS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [VEC_W-1:0] num_vec,
    input  logic             reload_w,
    output logic             w_rd_en,
    output logic [AW-1:0]    w_rd_addr,
    input  logic             fm_empty,
    output logic             fm_rd_en,
    output logic [VEC_W-1:0] fm_rd_addr,
    output logic             mac_wen,
    output logic [ROWS-1:0]  row_valid,
    output logic [COLS-1:0]  col_valid,
    output logic             busy,
    output logic             done
);

    // Tap k of the delay line is fm_rd_en delayed k+1 cycles (tap 0 = buffer latency)
    localparam int DEPTH    = ROWS + COLS + 1;
    localparam int COL_TAP0 = ROWS + 1;

    localparam logic [AW-1:0]    LOAD_LAST = AW'(ROWS - 1);
    localparam logic [AW-1:0]    LOAD_ONE  = AW'(1);
    localparam logic [VEC_W-1:0] VEC_ONE   = VEC_W'(1);

    sa_state_e        state_q, state_d;
    logic [AW-1:0]    load_cnt_q, load_cnt_d;
    logic [VEC_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [VEC_W-1:0] num_vec_q, num_vec_d;
    logic             mac_wen_q;
    logic             fm_rd_en_s;
    logic [DEPTH-1:0] taps_s;

    // State, counters and the one-cycle-late weight-capture strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            load_cnt_q <= '0;
            vec_cnt_q  <= '0;
            num_vec_q  <= '0;
            mac_wen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            vec_cnt_q  <= vec_cnt_d;
            num_vec_q  <= num_vec_d;
            mac_wen_q  <= (state_q == LOAD_W);
        end
    end

    // Next-state logic and the feature read strobe (follows fm_empty in the same cycle)
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        vec_cnt_d  = vec_cnt_q;
        num_vec_d  = num_vec_q;
        fm_rd_en_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    num_vec_d  = num_vec;
                    vec_cnt_d  = '0;
                    load_cnt_d = '0;
                    state_d    = reload_w ? LOAD_W : STREAM;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_W: begin
                if (load_cnt_q == LOAD_LAST) begin
                    load_cnt_d = '0;
                    state_d    = STREAM;
                end else begin
                    load_cnt_d = load_cnt_q + LOAD_ONE;
                end
            end
            STREAM: begin
                if (num_vec_q == '0) begin
                    state_d = DRAIN;
                end else if (!fm_empty) begin
                    fm_rd_en_s = 1'b1;
                    vec_cnt_d  = vec_cnt_q + VEC_ONE;
                    if (vec_cnt_q == (num_vec_q - VEC_ONE)) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = STREAM;
                    end
                end else begin
                    state_d = STREAM;
                end
            end
            DRAIN: begin
                if (taps_s == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    sa_valid_delay_line #(
        .DEPTH (DEPTH)
    ) u_valid_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (fm_rd_en_s),
        .taps (taps_s)
    );

    // Weight rows are fetched bottom row first so they shift down into place
    assign w_rd_en    = (state_q == LOAD_W);
    assign w_rd_addr  = (state_q == LOAD_W) ? (LOAD_LAST - load_cnt_q) : '0;
    assign fm_rd_en   = fm_rd_en_s;
    assign fm_rd_addr = (state_q == STREAM) ? vec_cnt_q : '0;
    assign mac_wen    = mac_wen_q;
    assign row_valid  = taps_s[ROWS-1:0];
    assign col_valid  = taps_s[COL_TAP0 +: COLS];
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_sa_weight_stream_ctrl.sv
// Self-checking bench for sa_weight_stream_ctrl: table of jobs plus random jobs,
// each compared cycle by cycle against a timeline model built from the job rules.
module tb_sa_weight_stream_ctrl;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int VEC_W = 8;
    localparam int AW    = 2;
    localparam int LEN   = 320;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [VEC_W-1:0] num_vec;
    logic             reload_w;
    logic             w_rd_en;
    logic [AW-1:0]    w_rd_addr;
    logic             fm_empty;
    logic             fm_rd_en;
    logic [VEC_W-1:0] fm_rd_addr;
    logic             mac_wen;
    logic [ROWS-1:0]  row_valid;
    logic [COLS-1:0]  col_valid;
    logic             busy;
    logic             done;

    sa_weight_stream_ctrl #(.ROWS(ROWS), .COLS(COLS), .VEC_W(VEC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_vec    (num_vec),
        .reload_w   (reload_w),
        .w_rd_en    (w_rd_en),
        .w_rd_addr  (w_rd_addr),
        .fm_empty   (fm_empty),
        .fm_rd_en   (fm_rd_en),
        .fm_rd_addr (fm_rd_addr),
        .mac_wen    (mac_wen),
        .row_valid  (row_valid),
        .col_valid  (col_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected per-cycle outputs, index = cycles after the start cycle
    int e_wen[LEN], e_waddr[LEN], e_mac[LEN], e_fren[LEN], e_fraddr[LEN];
    int e_row[LEN], e_col[LEN], e_busy[LEN], e_done[LEN];
    bit emp[LEN];

    typedef struct {
        int          n;
        bit          rel;
        logic [31:0] mask;        // fm_empty pattern, bit i = i-th cycle of streaming
        int          bstart;      // cycle of an extra start while busy (0 = none)
        int          exp_done;    // hand-computed done cycle
        int          exp_results; // results seen on the last column
    } vec_t;

    task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%0h want=%0h", nm, t, act, exp);
        end
    endtask

    // Build the expected timeline from the job rules: weight load, reads as
    // the feature buffer allows, fixed row/column latencies, done after drain.
    task automatic build_model(input int n, input bit rel, input bit rnd,
                               input logic [31:0] mask, output int done_t);
        int s_st, k, t, last;
        s_st = 1 + (rel ? ROWS : 0);
        for (int i = 0; i < LEN; i++) begin
            e_wen[i] = 0; e_waddr[i] = 0; e_mac[i] = 0; e_fren[i] = 0; e_fraddr[i] = 0;
            e_row[i] = 0; e_col[i] = 0; e_busy[i] = 0; e_done[i] = 0;
            if (rnd)
                emp[i] = ($urandom_range(0, 3) == 0);
            else if (i >= s_st && i - s_st < 32)
                emp[i] = mask[i - s_st];
            else
                emp[i] = 1'b0;
        end
        if (rel) begin
            for (int r = 0; r < ROWS; r++) begin
                e_wen[1 + r]   = 1;
                e_waddr[1 + r] = ROWS - 1 - r;
                e_mac[2 + r]   = 1;
            end
        end
        k = 0; t = s_st; last = s_st;
        while (k < n) begin
            e_fraddr[t] = k;
            if (!emp[t]) begin
                e_fren[t] = 1;
                for (int r = 0; r < ROWS; r++) e_row[t + 1 + r] |= (1 << r);
                for (int c = 0; c < COLS; c++) e_col[t + ROWS + 2 + c] |= (1 << c);
                last = t;
                k++;
            end
            t++;
        end
        done_t = (n == 0) ? s_st + 2 : last + ROWS + COLS + 3;
        for (int i = 1; i <= done_t; i++) e_busy[i] = 1;
        e_done[done_t] = 1;
    endtask

    task automatic run_job(input int n, input bit rel, input bit rnd, input logic [31:0] mask,
                           input int bstart, output int done_seen, output int results);
        int dt;
        build_model(n, rel, rnd, mask, dt);
        done_seen = -1;
        results   = 0;
        for (int t = 0; t <= dt + 2; t++) begin
            @(negedge clk);
            start    = (t == 0) || (bstart > 0 && t == bstart);
            num_vec  = (t == 0) ? n[VEC_W-1:0] : 8'd7;
            reload_w = (t == 0) ? rel : ~rel;
            fm_empty = emp[t];
            #1;
            chk("w_rd_en",    t, 32'(w_rd_en),    e_wen[t]);
            chk("w_rd_addr",  t, 32'(w_rd_addr),  (e_wen[t] != 0) ? e_waddr[t] : 0);
            chk("mac_wen",    t, 32'(mac_wen),    e_mac[t]);
            chk("fm_rd_en",   t, 32'(fm_rd_en),   e_fren[t]);
            if (e_fren[t] != 0) chk("fm_rd_addr", t, 32'(fm_rd_addr), e_fraddr[t]);
            chk("row_valid",  t, 32'(row_valid),  e_row[t]);
            chk("col_valid",  t, 32'(col_valid),  e_col[t]);
            chk("busy",       t, 32'(busy),       e_busy[t]);
            chk("done",       t, 32'(done),       e_done[t]);
            if (done === 1'b1 && done_seen < 0) done_seen = t;
            if (col_valid[COLS-1] === 1'b1) results++;
        end
        @(negedge clk);
        start    = 1'b0;
        fm_empty = 1'b0;
    endtask

    vec_t tbl[7];
    int   ds, rs, rn;

    initial begin
        rst = 1'b1; start = 1'b0; num_vec = '0; reload_w = 1'b0; fm_empty = 1'b0;

        // Hand-computed job table; done cycle counted from the start cycle
        tbl[0] = '{n: 3,   rel: 1'b1, mask: 32'h0000_0000, bstart: 8, exp_done: 18,  exp_results: 3};
        tbl[1] = '{n: 2,   rel: 1'b0, mask: 32'h0000_0000, bstart: 0, exp_done: 13,  exp_results: 2};
        tbl[2] = '{n: 4,   rel: 1'b1, mask: 32'h0000_000C, bstart: 0, exp_done: 21,  exp_results: 4};
        tbl[3] = '{n: 0,   rel: 1'b1, mask: 32'h0000_0000, bstart: 6, exp_done: 7,   exp_results: 0};
        tbl[4] = '{n: 0,   rel: 1'b0, mask: 32'h0000_0000, bstart: 0, exp_done: 3,   exp_results: 0};
        tbl[5] = '{n: 1,   rel: 1'b0, mask: 32'h0000_0000, bstart: 0, exp_done: 12,  exp_results: 1};
        tbl[6] = '{n: 255, rel: 1'b0, mask: 32'h0000_0000, bstart: 100, exp_done: 266, exp_results: 255};

        // Reset state
        #2;
        chk("rst_busy",  0, 32'(busy), 0);
        chk("rst_outs",  0, {w_rd_en, fm_rd_en, mac_wen, done, row_valid, col_valid}, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_job(tbl[i].n, tbl[i].rel, 1'b0, tbl[i].mask, tbl[i].bstart, ds, rs);
            chk("tbl_done_cycle", i, ds, tbl[i].exp_done);
            chk("tbl_results",    i, rs, tbl[i].exp_results);
        end

        // Random jobs with random buffer stalls
        for (int j = 0; j < 10; j++) begin
            rn = $urandom_range(0, 20);
            run_job(rn, 1'($urandom_range(0, 1)), 1'b1, 32'h0, 0, ds, rs);
            chk("rnd_results", j, rs, rn);
        end

        // Reset in the middle of streaming: outputs clear at once, no done later
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            start = (t == 0); num_vec = 8'd10; reload_w = 1'b0; fm_empty = 1'b0;
        end
        #1;
        chk("pre_rst_stream", 0, 32'(fm_rd_en), 1);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_outs", 0, {w_rd_en, fm_rd_en, mac_wen, busy, done, fm_rd_addr, row_valid, col_valid}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            #1;
            chk("post_rst_idle", t, {fm_rd_en, mac_wen, busy, done, row_valid, col_valid}, 0);
        end

        // Weights must be reloaded after the abort; a full job still works
        run_job(2, 1'b1, 1'b0, 32'h0, 0, ds, rs);
        chk("after_rst_done", 0, ds, 17);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
